xif_alu_coproc: RTL



---
 rtl/xif_alu_coproc_if.sv | 43 ++++
 rtl/xif_alu_coproc.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/xif_alu_coproc_if.sv
// X-interface issue/commit/result channel bundle between the core and the
// ALU coprocessor. The coprocessor uses the slave view, the core (or the
// bench standing in for it) uses the master view.
interface xif_alu_coproc_if #(
  parameter int ID_WIDTH = 4
);
  logic                issue_valid_i;
  logic                issue_ready_o;
  logic [31:0]         issue_instr_i;
  logic [ID_WIDTH-1:0] issue_id_i;
  logic [31:0]         issue_rs0_i;
  logic [31:0]         issue_rs1_i;
  logic [1:0]          issue_rs_valid_i;
  logic                issue_accept_o;
  logic                issue_writeback_o;

  logic                commit_valid_i;
  logic [ID_WIDTH-1:0] commit_id_i;
  logic                commit_kill_i;

  logic                result_valid_o;
  logic                result_ready_i;
  logic [ID_WIDTH-1:0] result_id_o;
  logic [31:0]         result_data_o;
  logic [4:0]          result_rd_o;
  logic                result_we_o;

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs0_i, issue_rs1_i,
           issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i,
           result_ready_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o, result_valid_o,
           result_id_o, result_data_o, result_rd_o, result_we_o
  );

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs0_i, issue_rs1_i,
           issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i,
           result_ready_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o, result_valid_o,
           result_id_o, result_data_o, result_rd_o, result_we_o
  );
endinterface

// File: rtl/xif_alu_coproc.sv
// Minimal X-interface ALU coprocessor. Accepts custom-0 R-type add/xor/and/or,
// computes the value at issue time, holds it in an in-order queue until the
// core commits or kills it, and returns committed results strictly in order.
module xif_alu_coproc #(
  parameter int         DEPTH    = 4,
  parameter int         ID_WIDTH = 4,
  parameter logic [6:0] OPCODE   = 7'h0B
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  xif_alu_coproc_if.slave        xif,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Queue state
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH-1:0]    committed_q, committed_d;
  logic [DEPTH-1:0]    killed_q, killed_d;
  logic [ID_WIDTH-1:0] id_q   [DEPTH];
  logic [ID_WIDTH-1:0] id_d   [DEPTH];
  logic [4:0]          rd_q   [DEPTH];
  logic [4:0]          rd_d   [DEPTH];
  logic [31:0]         data_q [DEPTH];
  logic [31:0]         data_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  // Decode / datapath
  logic [2:0]       funct3;
  logic             decode_ok;
  logic             issue_ready;
  logic             push;
  logic [31:0]      alu_result;
  logic             head_valid;
  logic             result_valid;
  logic             kill_pop;
  logic             pop;
  logic             match_found;
  logic [PTR_W-1:0] match_idx;
  logic [PTR_W-1:0] search_idx;
  logic             commit_new;

  // Register-source and funct fields outside the decoded ones are not needed.
  logic unused_instr_bits;
  assign unused_instr_bits = ^xif.issue_instr_i[24:15];

  assign funct3 = xif.issue_instr_i[14:12];

  // Combinational decode and ALU so accept/writeback answer in the handshake cycle
  always_comb begin
    decode_ok   = (xif.issue_instr_i[6:0] == OPCODE) &&
                  (xif.issue_instr_i[31:25] == 7'd0) && !funct3[2];
    // No bypass: a full queue refuses issue even when a pop happens this cycle.
    issue_ready = (xif.issue_rs_valid_i == 2'b11) && (count_q < CNT_W'(DEPTH));
    push        = xif.issue_valid_i && issue_ready && decode_ok;
    alu_result  = '0;
    case (funct3[1:0])
      2'b00:   alu_result = xif.issue_rs0_i + xif.issue_rs1_i;
      2'b01:   alu_result = xif.issue_rs0_i ^ xif.issue_rs1_i;
      2'b10:   alu_result = xif.issue_rs0_i & xif.issue_rs1_i;
      default: alu_result = xif.issue_rs0_i | xif.issue_rs1_i;
    endcase
  end

  assign xif.issue_ready_o     = issue_ready;
  assign xif.issue_accept_o    = xif.issue_valid_i && decode_ok;
  assign xif.issue_writeback_o = xif.issue_valid_i && decode_ok;

  // Head status: committed heads are offered to the core, killed heads drop silently
  always_comb begin
    head_valid   = valid_q[rd_ptr_q];
    result_valid = head_valid && committed_q[rd_ptr_q];
    kill_pop     = head_valid && killed_q[rd_ptr_q];
    pop          = kill_pop || (result_valid && xif.result_ready_i);
  end

  // Find the oldest unresolved entry carrying the commit id, walking from the head
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    search_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      search_idx = rd_ptr_q + PTR_W'(k);
      if (!match_found && valid_q[search_idx] && !committed_q[search_idx] &&
          !killed_q[search_idx] && (id_q[search_idx] == xif.commit_id_i)) begin
        match_found = 1'b1;
        match_idx   = search_idx;
      end
    end
    // Entries already queued are older than the one arriving now, so they win;
    // otherwise a commit naming the id being issued resolves the new entry.
    commit_new = xif.commit_valid_i && !match_found && push &&
                 (xif.issue_id_i == xif.commit_id_i);
  end

  // Next queue state: pop at head, resolve on commit, push at tail
  always_comb begin
    valid_d     = valid_q;
    committed_d = committed_q;
    killed_d    = killed_q;
    id_d        = id_q;
    rd_d        = rd_q;
    data_d      = data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (pop) begin
      valid_d[rd_ptr_q]     = 1'b0;
      committed_d[rd_ptr_q] = 1'b0;
      killed_d[rd_ptr_q]    = 1'b0;
      rd_ptr_d              = rd_ptr_q + PTR_W'(1);
    end

    if (xif.commit_valid_i && match_found) begin
      if (xif.commit_kill_i) killed_d[match_idx]    = 1'b1;
      else                   committed_d[match_idx] = 1'b1;
    end

    if (push) begin
      valid_d[wr_ptr_q]     = 1'b1;
      committed_d[wr_ptr_q] = commit_new && !xif.commit_kill_i;
      killed_d[wr_ptr_q]    = commit_new && xif.commit_kill_i;
      id_d[wr_ptr_q]        = xif.issue_id_i;
      rd_d[wr_ptr_q]        = xif.issue_instr_i[11:7];
      data_d[wr_ptr_q]      = alu_result;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every entry, resolved or not
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      committed_q <= '0;
      killed_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]   <= '0;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      committed_q <= committed_d;
      killed_q    <= killed_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      id_q        <= id_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
    end
  end

  // Result channel straight from registered head state; payload zero when idle
  always_comb begin
    xif.result_valid_o = result_valid;
    xif.result_we_o    = result_valid;
    xif.result_id_o    = result_valid ? id_q[rd_ptr_q]   : '0;
    xif.result_rd_o    = result_valid ? rd_q[rd_ptr_q]   : '0;
    xif.result_data_o  = result_valid ? data_q[rd_ptr_q] : '0;
  end

  assign count_o = count_q;

endmodule
